// File: rtl/usb_rx_bit_timer.sv
// usb_rx_bit_timer
//   Receive-side bit timing and bit-unstuffing for the USB full-speed receiver.
//   It recovers bit timing from an oversampled clock and resynchronises on
//   every line transition. It strobes the NRZI decoder, drops stuffed zeros,
//   flags stuffing violations and pulses once per 8 payload bits.
//
// Parameters
//   CLKS_PER_BIT   clk cycles per USB bit (4..16)
//   SAMPLE_POINT   phase index at which shift_enable fires (< CLKS_PER_BIT)
//
// Ports
//   clk            system clock, CLKS_PER_BIT x bit rate
//   n_rst          asynchronous active-low reset
//   rcving         packet receive in progress; low clears all counters
//   d_edge         one-cycle pulse on any D+ transition
//   d_orig         decoded NRZI bit, valid while shift_enable is high
//   shift_enable   one-cycle strobe to the decoder: sample now
//   bit_valid      one-cycle strobe: d_orig is a payload bit
//   stuff_err      one-cycle pulse: seventh consecutive 1 seen
//   byte_received  registered one-cycle pulse after the 8th payload bit
module usb_rx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned SAMPLE_POINT = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic rcving,
    input  logic d_edge,
    input  logic d_orig,
    output logic shift_enable,
    output logic bit_valid,
    output logic stuff_err,
    output logic byte_received
);

    localparam int unsigned PHASE_W = $clog2(CLKS_PER_BIT);
    localparam logic [PHASE_W-1:0] PHASE_LAST   = PHASE_W'(CLKS_PER_BIT - 1);
    localparam logic [PHASE_W-1:0] PHASE_SAMPLE = PHASE_W'(SAMPLE_POINT);
    localparam logic [2:0]         STUFF_SLOT   = 3'd6;
    localparam logic [2:0]         LAST_BIT     = 3'd7;

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_next;
    logic [2:0]         ones;
    logic [2:0]         ones_next;
    logic [2:0]         bit_cnt;
    logic [2:0]         bit_cnt_next;
    logic               byte_next;
    logic               stuff_slot;

    // Strobe is decoded from the registered phase, so an edge arriving in
    // the sample cycle still gets its sample; the restart lands next cycle.
    always_comb begin
        shift_enable = rcving && (phase == PHASE_SAMPLE);
        stuff_slot   = (ones == STUFF_SLOT);
        bit_valid    = shift_enable && !stuff_slot;
        stuff_err    = shift_enable && stuff_slot && d_orig;
    end

    always_comb begin
        phase_next = phase + 1'b1;
        if (!rcving || d_edge || (phase == PHASE_LAST)) begin
            phase_next = '0;
        end
    end

    // The stuff slot consumes the bit whatever its value; a 1 there is the
    // violation, and the run restarts either way.
    always_comb begin
        ones_next = ones;
        if (!rcving) begin
            ones_next = '0;
        end else if (shift_enable) begin
            if (stuff_slot || !d_orig) begin
                ones_next = '0;
            end else begin
                ones_next = ones + 3'd1;
            end
        end
    end

    always_comb begin
        bit_cnt_next = bit_cnt;
        byte_next    = 1'b0;
        if (!rcving) begin
            bit_cnt_next = '0;
        end else if (bit_valid) begin
            bit_cnt_next = bit_cnt + 3'd1;
            byte_next    = (bit_cnt == LAST_BIT);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase         <= '0;
            ones          <= '0;
            bit_cnt       <= '0;
            byte_received <= 1'b0;
        end else begin
            phase         <= phase_next;
            ones          <= ones_next;
            bit_cnt       <= bit_cnt_next;
            byte_received <= byte_next;
        end
    end

endmodule
